// File: rtl/ecc_52_enc_pipe_if.sv
// Handshake bundle for the 52-bit SECDED write-side encoder: input beat stream
// and registered codeword stream.
interface ecc_52_enc_pipe_if #(
  parameter int DATA_WIDTH   = 52,
  parameter int PARITY_WIDTH = 7
);
  // valid/ready: a transfer happens on a rising edge where both are 1. The
  // sender holds valid and payload stable until the transfer and never
  // derives valid from ready; the receiver may change ready at any time.
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_bypass;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic [PARITY_WIDTH-1:0] out_parity;

  modport master (
    output in_valid, in_data, in_bypass, out_ready,
    input  in_ready, out_valid, out_data, out_parity
  );

  modport slave (
    input  in_valid, in_data, in_bypass, out_ready,
    output in_ready, out_valid, out_data, out_parity
  );
endinterface

// File: rtl/ecc_52_enc_pipe.sv
// SECDED (59,52) write-side encoder with a 2-entry registered skid buffer.
// Optional error injection is enabled by defining ECC_52_ERR_INJ_EN.
module ecc_52_enc_pipe #(
  parameter int DATA_WIDTH   = 52,
  parameter int PARITY_WIDTH = 7,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ecc_52_enc_pipe_if.slave     bus,
  output logic [CNT_WIDTH-1:0] enc_cnt,
  output logic [1:0]           dbg_state
`ifdef ECC_52_ERR_INJ_EN
  ,
  input  logic                               inj_arm,
  input  logic [DATA_WIDTH+PARITY_WIDTH-1:0] inj_mask,
  output logic                               inj_done
`endif
);

  localparam int CW = DATA_WIDTH + PARITY_WIDTH;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  // Column k: the (k+1)-th non-power-of-two from 3 upward, with bit 6 making
  // the column weight odd so every single-bit error has an odd syndrome.
  function automatic logic [6:0] h_col(input int k);
    logic [6:0] col;
    logic [5:0] low;
    int         idx;
    col = '0;
    idx = 0;
    for (int n = 3; n < 64; n++) begin
      if ((n & (n - 1)) != 0) begin
        if (idx == k) begin
          low = n[5:0];
          col = {~^low, low};
        end
        idx++;
      end
    end
    return col;
  endfunction

  logic [PARITY_WIDTH-1:0] h_cols [DATA_WIDTH];

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_col
    assign h_cols[g] = h_col(g);
  end

  state_t                 state_q, state_d;
  logic [CW-1:0]          head_q, head_d;
  logic [CW-1:0]          tail_q, tail_d;
  logic                   out_valid_q, out_valid_d;
  logic                   in_ready_q, in_ready_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic                    accept;
  logic                    consume;
  logic [PARITY_WIDTH-1:0] parity_c;
  logic [CW-1:0]           clean_cw;
  logic [CW-1:0]           new_cw;

  assign accept  = bus.in_valid & in_ready_q;
  assign consume = out_valid_q & bus.out_ready;

  always_comb begin
    parity_c = '0;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      if (bus.in_data[k]) begin
        parity_c = parity_c ^ h_cols[k];
      end
    end
    if (bus.in_bypass) begin
      parity_c = '0;
    end
  end

  assign clean_cw = {parity_c, bus.in_data};

`ifdef ECC_52_ERR_INJ_EN
  logic inj_armed_q, inj_armed_d;
  logic inj_done_q, inj_done_d;
  logic inj_fire;

  // An arm pulse coinciding with an accept applies to that same beat.
  always_comb begin
    inj_fire    = accept & (inj_armed_q | inj_arm);
    inj_armed_d = (inj_armed_q | inj_arm) & ~accept;
    inj_done_d  = inj_fire;
    new_cw      = inj_fire ? (clean_cw ^ inj_mask) : clean_cw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_armed_q <= 1'b0;
      inj_done_q  <= 1'b0;
    end else begin
      inj_armed_q <= inj_armed_d;
      inj_done_q  <= inj_done_d;
    end
  end

  assign inj_done = inj_done_q;
`else
  assign new_cw = clean_cw;
`endif

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          head_d  = new_cw;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && consume) begin
          head_d = new_cw;
        end else if (accept) begin
          tail_d  = new_cw;
          state_d = S_TWO;
        end else if (consume) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        // in_ready is low here, so only the consume side can move.
        if (consume) begin
          head_d  = tail_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    out_valid_d = (state_d != S_EMPTY);
    in_ready_d  = (state_d != S_TWO);
    cnt_d       = cnt_q;
    if (accept && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = head_q[DATA_WIDTH-1:0];
  assign bus.out_parity = head_q[CW-1:DATA_WIDTH];
  assign enc_cnt        = cnt_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_ecc_52_enc_pipe.sv
// Directed bench for ecc_52_enc_pipe: H-matrix anchors, bypass, backpressure,
// streaming order, injection (when ECC_52_ERR_INJ_EN), reset and saturation.
module tb_ecc_52_enc_pipe;

  logic        clk;
  logic        rst_n;
  logic [15:0] enc_cnt;
  logic [1:0]  dbg_state;
`ifdef ECC_52_ERR_INJ_EN
  logic        inj_arm;
  logic [58:0] inj_mask;
  logic        inj_done;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  logic [58:0] exp_q[$];
  logic [6:0]  cols [52];

  ecc_52_enc_pipe_if bus ();

  ecc_52_enc_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .enc_cnt   (enc_cnt),
    .dbg_state (dbg_state)
`ifdef ECC_52_ERR_INJ_EN
    ,
    .inj_arm   (inj_arm),
    .inj_mask  (inj_mask),
    .inj_done  (inj_done)
`endif
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference columns built by counting over integers, skipping powers of two.
  task automatic build_cols();
    int n;
    n = 3;
    for (int k = 0; k < 52; k++) begin
      while ($countones(n) == 1) n++;
      cols[k][5:0] = n[5:0];
      cols[k][6]   = ($countones(n[5:0]) % 2 == 0);
      n++;
    end
  endtask

  function automatic logic [6:0] model_parity(input logic [51:0] d);
    logic [6:0] p;
    p = '0;
    for (int k = 0; k < 52; k++) begin
      if (d[k]) p = p ^ cols[k];
    end
    return p;
  endfunction

  // driver: one beat through an idle pipe with out_ready high
  task automatic send_one(input string tag, input logic [51:0] d, input logic byp,
                          input logic [51:0] exp_d, input logic [6:0] exp_p);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_bypass = byp;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    bus.in_bypass = 1'b0;
    exp_cnt++;
    chk({tag, "_valid"}, bus.out_valid, 1'b1);
    chk({tag, "_data"}, bus.out_data, exp_d);
    chk({tag, "_parity"}, bus.out_parity, exp_p);
    step();
    chk({tag, "_drain"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    logic [51:0] a, b, d;
    logic [31:0] r0, r1;
    logic [58:0] exp_cw;

    build_cols();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b0;
`ifdef ECC_52_ERR_INJ_EN
    inj_arm  = 1'b0;
    inj_mask = '0;
`endif

    // reset values
    step();
    step();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 52'h0);
    chk("rst_out_parity", bus.out_parity, 7'h0);
    chk("rst_enc_cnt", enc_cnt, 16'h0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", bus.in_ready, 1'b1);

    // H-matrix anchors
    send_one("h_zero", 52'h0, 1'b0, 52'h0, 7'h00);
    send_one("h_bit0", 52'h1, 1'b0, 52'h1, 7'b1000011);
    send_one("h_bit51", 52'h8_0000_0000_0000, 1'b0, 52'h8_0000_0000_0000, 7'b1111010);
    send_one("h_bit3", 52'h8, 1'b0, 52'h8, 7'b0000111);
    send_one("h_bits01", 52'h3, 1'b0, 52'h3, 7'b0000110);

    // bypass
    send_one("bypass", 52'h1, 1'b1, 52'h1, 7'h00);

    // backpressure: fill both entries, hold, then drain
    a = 52'h0_A5A5_5A5A_1234;
    b = 52'hF_0F0F_1111_2222;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = a;
    step();
    chk("bp_ready_one", bus.in_ready, 1'b1);
    bus.in_data = b;
    step();
    exp_cnt += 2;
    bus.in_data = 52'h1_2345_6789_ABCD;
    chk("bp_ready_two", bus.in_ready, 1'b0);
    chk("bp_head_a", bus.out_data, a);
    chk("bp_head_a_par", bus.out_parity, model_parity(a));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_valid", bus.out_valid, 1'b1);
      chk("bp_hold_data", bus.out_data, a);
      chk("bp_hold_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("bp_head_b", bus.out_data, b);
    chk("bp_head_b_par", bus.out_parity, model_parity(b));
    chk("bp_head_b_valid", bus.out_valid, 1'b1);
    chk("bp_ready_back", bus.in_ready, 1'b1);
    step();
    chk("bp_empty", bus.out_valid, 1'b0);
    chk("bp_cnt", enc_cnt, exp_cnt[15:0]);

    // streaming: 100 beats, one per cycle, strict order
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      r0 = $urandom;
      r1 = $urandom_range(0, 32'hFFFFF);
      d  = {r1[19:0], r0};
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      exp_q.push_back({model_parity(d), d});
      step();
      exp_cnt++;
      exp_cw = exp_q.pop_front();
      chk("stream_valid", bus.out_valid, 1'b1);
      chk("stream_cw", {bus.out_parity, bus.out_data}, exp_cw);
    end
    bus.in_valid = 1'b0;
    step();
    chk("stream_empty", bus.out_valid, 1'b0);
    chk("stream_cnt", enc_cnt, exp_cnt[15:0]);

`ifdef ECC_52_ERR_INJ_EN
    // error injection
    inj_mask = 59'h20;
    inj_arm  = 1'b1;
    step();
    inj_arm = 1'b0;
    chk("inj_arm_no_done", inj_done, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 52'h0;
    step();
    bus.in_valid = 1'b0;
    exp_cnt++;
    chk("inj5_data", bus.out_data, 52'h20);
    chk("inj5_parity", bus.out_parity, 7'h00);
    chk("inj5_done", inj_done, 1'b1);
    step();
    chk("inj5_done_clear", inj_done, 1'b0);
    inj_mask     = 59'h1 | (59'h1 << 52);
    inj_arm      = 1'b1;
    bus.in_valid = 1'b1;
    step();
    inj_arm      = 1'b0;
    bus.in_valid = 1'b0;
    exp_cnt++;
    chk("inj0_data", bus.out_data, 52'h1);
    chk("inj0_parity", bus.out_parity, 7'h01);
    chk("inj0_done", inj_done, 1'b1);
    step();
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    exp_cnt++;
    chk("inj_clean_data", bus.out_data, 52'h0);
    chk("inj_clean_parity", bus.out_parity, 7'h00);
    chk("inj_clean_done", inj_done, 1'b0);
    step();
    inj_mask = '0;
    chk("inj_cnt", enc_cnt, exp_cnt[15:0]);
`endif

    // asynchronous reset with the buffer full
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 52'h5_5555_5555_5555;
    step();
    bus.in_data = 52'hA_AAAA_AAAA_AAAA;
    step();
    bus.in_valid = 1'b0;
    chk("mid_full", bus.in_ready, 1'b0);
    chk("mid_valid", bus.out_valid, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_cnt", enc_cnt, exp_cnt[15:0]);
    chk("mid_rst_data", bus.out_data, 52'h0);
    step();
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk("post_rst_ready", bus.in_ready, 1'b1);
    chk("post_rst_valid", bus.out_valid, 1'b0);
    step();
    step();
    chk("post_rst_no_stale", bus.out_valid, 1'b0);

    // counter saturation
    bus.in_valid = 1'b1;
    bus.in_data  = 52'h1;
    for (int i = 0; i < 65540; i++) step();
    bus.in_valid = 1'b0;
    step();
    chk("cnt_saturate", enc_cnt, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ecc_52_enc_pipe.md
Name: ecc_52_enc_pipe

Overview:
Write-side SECDED encoder for the 52-bit ECC-protected FIFO/SRAM path. It takes 52-bit data beats on a valid/ready interface and computes the 7-bit parity using the H-matrix the read-side corrector checks against. It emits a registered 59-bit codeword (data plus parity) through a 2-entry skid buffer that sits in front of the SRAM write port. The block provides full throughput, a one-cycle latency and lossless backpressure.

Parameters:
DATA_WIDTH, 52, data bits per beat; only 52 is legal.
PARITY_WIDTH, 7, parity bits per beat; only 7 is legal.
CNT_WIDTH, 16, width of the accepted-beat counter.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_data is presented.
in_ready  output  1  block can accept a beat.
in_data  input  52  data to encode.
in_bypass  input  1  sampled with the beat; when 1, parity is forced to 0.
out_valid  output  1  codeword is presented.
out_ready  input  1  downstream accepts the codeword.
out_data  output  52  data field of the codeword.
out_parity  output  7  parity field of the codeword.
enc_cnt  output  CNT_WIDTH  number of accepted beats, saturating.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - out_valid=0, out_data=0, out_parity=0, enc_cnt=0.
  - in_ready=1 on the first edge after reset is released.
- H-matrix:
  - Data bit k has column c[k][6:0].
  - c[k][5:0] is the (k+1)-th integer in ascending order from 3 upward that is not a power of two: 3,5,6,7,9,...,58.
  - c[k][6] is set so that popcount(c[k]) is odd.
  - Checks: c[0]=7'b1000011, c[3]=7'b0000111, c[51]=7'b1111010.
- Parity: parity[j] = XOR of in_data[k] over all k with c[k][j]=1. If in_bypass=1, parity=0.
- Accept and present:
  - A beat is accepted when in_valid & in_ready.
  - A beat is presented when out_valid; it is consumed when out_valid & out_ready.
  - Parity is computed combinationally on accept and registered with the data. There is no combinational path from in_data to the outputs.
- Skid buffer states (count of stored beats):
  - EMPTY: accept → ONE.
  - ONE: accept with no consume → TWO; consume with no accept → EMPTY; accept and consume together → ONE.
  - TWO: in_ready=0; consume → ONE.
- in_ready is registered and equals (state != TWO). It never depends combinationally on out_ready.
- Latency: a beat accepted at edge N drives out_valid=1 after edge N, provided the buffer was EMPTY or the head was consumed at N.
- Ordering is strict FIFO. Output contents and out_valid stay stable until consumed.
- Throughput: with out_ready held at 1, one beat per cycle sustained.
- Simultaneous accept and consume while in ONE: the head is replaced by the new beat with no bubble.
- enc_cnt increments on each accept and saturates at 2^CNT_WIDTH-1; it does not wrap.
- Reset asserted mid-stream: both entries are dropped, out_valid falls immediately (asynchronous), and enc_cnt clears.
- The in_valid/in_ready protocol is the standard one: in_valid must not depend on in_ready.

Optional Feature:
Macro ECC_52_ERR_INJ_EN.
- Defined:
  - Adds ports inj_arm (input 1), inj_mask (input 59; bits [51:0] are data, [58:52] are parity) and inj_done (output 1, one-cycle pulse).
  - A pulse on inj_arm sets an armed flag; a pulse while already armed has no extra effect.
  - The next accepted beat has its registered codeword XORed with the inj_mask value sampled at accept time.
  - The flag then clears and inj_done pulses in the accept cycle+1.
  - inj_arm coinciding with an accept injects that same beat.
  - Reset clears the armed flag.
- Undefined: the ports are absent, the codeword is always clean, and no injection logic is present.

Test Plan:
1. in_data=0, in_bypass=0 → out_parity=7'h00. in_data=52'h1 → 7'b1000011. in_data=1<<51 → 7'b1111010. in_data=1<<3 → 7'b0000111.
2. in_data=52'h1 with in_bypass=1 → out_data=52'h1, out_parity=0.
3. out_ready=0, push beats A,B → in_ready=0 after the second accept. Hold 3 cycles, then out_ready=1 → A then B on consecutive cycles, with in_ready back to 1 after the A consume.
4. in_valid=out_ready=1 for 100 random beats → 100 outputs in order, one per cycle, with parity matching the H-matrix model and enc_cnt=100.
5. Buffer in TWO, assert rst_n=0 mid-cycle → out_valid=0 immediately and enc_cnt=0. After release, in_ready=1 and no stale beats are output.
6. With ECC_52_ERR_INJ_EN: arm with mask bit 5, send 52'h0 → out_data=52'h20, parity 0, and inj_done pulse. Arm with mask bits 0 and 52 → data bit 0 and parity bit 0 are flipped. The next beat is clean.
